// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive pixel unpacker: default header,
// one-hot FSM encoding and the error-counter width.
package udp_rx_pkg;

  localparam logic [31:0] FRAME_HEAD_DEF = 32'hF3ED7A93;
  localparam int          ERR_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    REC  = 2'b10
  } state_t;

endpackage

// File: rtl/udp_rx_pix_unpack_hdr_det.sv
// Zero-latency frame-header detector: a 24-bit history of valid bytes is
// compared together with the byte currently on the bus.
module udp_rx_hdr_det
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] FRAME_HEAD = FRAME_HEAD_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       valid,
  input  logic [7:0] data,
  input  logic       clr,
  output logic       hdr_match
);

  logic [23:0] sh;

  assign hdr_match = valid && ({sh, data} == FRAME_HEAD);

  // Clearing on an accepted match keeps trailing header bytes from
  // contributing to a second match.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh <= '0;
    end else if (clr) begin
      sh <= '0;
    end else if (valid) begin
      sh <= {sh[15:0], data};
    end
  end

endmodule

// File: rtl/udp_rx_pix_unpack.sv
// Byte-stream to pixel unpacker with VTC-style vs/hs/de and timeout recovery.
// Optional UDP_RX_RESYNC_EN: a header seen mid-frame aborts and restarts.
module udp_rx_pix_unpack
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] FRAME_HEAD = FRAME_HEAD_DEF,
  parameter int          PIX_BYTES  = 2,
  parameter int          H_ACT      = 640,
  parameter int          V_ACT      = 480,
  parameter int          TIMEOUT    = 50000
) (
  input  logic                   app_rx_clk,
  input  logic                   rstn,
  input  logic                   app_rx_data_valid,
  input  logic [7:0]             app_rx_data,
  output logic                   vid_clk,
  output logic                   vid_vs,
  output logic                   vid_hs,
  output logic                   vid_de,
  output logic [8*PIX_BYTES-1:0] vid_data,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int PIX_W  = 8 * PIX_BYTES;
  localparam int BI_W   = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
  localparam int X_W    = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int Y_W    = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t               state_q, state_nx;
  logic [BI_W-1:0]      idx_q, idx_nx;
  logic [X_W-1:0]       x_q, x_nx;
  logic [Y_W-1:0]       y_q, y_nx;
  logic [IDLE_W-1:0]    idle_q, idle_nx;
  logic [PIX_W-1:0]     acc_q, acc_nx, pix_next;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_nx;
  logic                 vs_nx, hs_nx, de_nx, done_nx, err_nx;
  logic [PIX_W-1:0]     data_nx;
  logic                 hdr_match, sh_clr, resync_hit;

  assign vid_clk = app_rx_clk;
  assign err_cnt = err_cnt_q;

  udp_rx_hdr_det #(
    .FRAME_HEAD (FRAME_HEAD)
  ) u_hdr_det (
    .clk       (app_rx_clk),
    .rstn      (rstn),
    .valid     (app_rx_data_valid),
    .data      (app_rx_data),
    .clr       (sh_clr),
    .hdr_match (hdr_match)
  );

`ifdef UDP_RX_RESYNC_EN
  assign resync_hit = hdr_match;
`else
  assign resync_hit = 1'b0;
`endif

  // First received byte ends up in the MSBs.
  assign pix_next = PIX_W'({acc_q, app_rx_data});

  always_comb begin
    state_nx   = state_q;
    idx_nx     = idx_q;
    x_nx       = x_q;
    y_nx       = y_q;
    idle_nx    = idle_q;
    acc_nx     = acc_q;
    err_cnt_nx = err_cnt_q;
    vs_nx      = 1'b0;
    hs_nx      = 1'b0;
    de_nx      = 1'b0;
    data_nx    = '0;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    sh_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hdr_match) begin
          state_nx = REC;
          idx_nx   = '0;
          x_nx     = '0;
          y_nx     = '0;
          idle_nx  = '0;
          vs_nx    = 1'b1;
          sh_clr   = 1'b1;
        end
      end
      REC: begin
        if (resync_hit) begin
          idx_nx     = '0;
          x_nx       = '0;
          y_nx       = '0;
          idle_nx    = '0;
          vs_nx      = 1'b1;
          err_nx     = 1'b1;
          err_cnt_nx = sat_inc(err_cnt_q);
          sh_clr     = 1'b1;
        end else if (app_rx_data_valid) begin
          idle_nx = '0;
          acc_nx  = pix_next;
          if (idx_q == BI_W'(PIX_BYTES - 1)) begin
            idx_nx  = '0;
            de_nx   = 1'b1;
            data_nx = pix_next;
            hs_nx   = (x_q == '0);
            if (x_q == X_W'(H_ACT - 1)) begin
              x_nx = '0;
              if (y_q == Y_W'(V_ACT - 1)) begin
                y_nx     = '0;
                done_nx  = 1'b1;
                state_nx = IDLE;
              end else begin
                y_nx = y_q + 1'b1;
              end
            end else begin
              x_nx = x_q + 1'b1;
            end
          end else begin
            idx_nx = idx_q + 1'b1;
          end
        end else if (idle_q == IDLE_W'(TIMEOUT)) begin
          err_nx     = 1'b1;
          err_cnt_nx = sat_inc(err_cnt_q);
          state_nx   = IDLE;
        end else begin
          idle_nx = idle_q + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      idle_q     <= '0;
      acc_q      <= '0;
      err_cnt_q  <= '0;
      vid_vs     <= 1'b0;
      vid_hs     <= 1'b0;
      vid_de     <= 1'b0;
      vid_data   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_nx;
      idx_q      <= idx_nx;
      x_q        <= x_nx;
      y_q        <= y_nx;
      idle_q     <= idle_nx;
      acc_q      <= acc_nx;
      err_cnt_q  <= err_cnt_nx;
      vid_vs     <= vs_nx;
      vid_hs     <= hs_nx;
      vid_de     <= de_nx;
      vid_data   <= data_nx;
      frame_done <= done_nx;
      frame_err  <= err_nx;
    end
  end

endmodule
